rgb_fade_sequencer: RTL and testbench

Drives the RGB LED from a queue-less command interface. Each command gives a target colour and a hold time. The block ramps the three PWM duty values one step per fade tick toward the target, holds the colour, then returns to idle. It contains a shared free-running PWM counter, per-channel glitch-free duty shadowing, a tick divider and the fade/hold FSM, and sits directly between top-level control logic and the LED pins.

---
 rtl/rgb_fade_sequencer.sv | 156 +++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer
//   Accepts one colour command at a time, ramps the three PWM duties one
//   step per fade tick toward the target, holds for cmd_hold ticks, then
//   returns to idle. LEDs keep showing the last colour while idle.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   cmd_valid/ready command handshake (ready only in IDLE)
//   cmd_rgb         target colour {r,g,b}, r in MSBs
//   cmd_hold        hold time in ticks once the target is reached
//   led_r/g/b       registered PWM outputs, active high
//   busy            FSM not in IDLE
//   cur_rgb         live (unshadowed) duty {r,g,b}

// Per-channel duty: target/current value, PWM shadow and LED register.
module rgb_fade_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PWM_BITS-1:0] load_val,
    input  logic                step,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                pwm_wrap,
    output logic [PWM_BITS-1:0] cur,
    output logic                at_tgt,
    output logic                led
);
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] shadow;

    assign at_tgt = (cur == target);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target <= '0;
            cur    <= '0;
            shadow <= '0;
            led    <= 1'b0;
        end else begin
            if (load)
                target <= load_val;
            // Moving only toward target makes over/underflow impossible.
            if (step) begin
                if (cur < target)
                    cur <= cur + PWM_BITS'(1);
                else if (cur > target)
                    cur <= cur - PWM_BITS'(1);
            end
            // Reload on the last count so a new duty starts cleanly at count 0.
            if (pwm_wrap)
                shadow <= cur;
            led <= (pwm_cnt < shadow);
        end
    end
endmodule

module rgb_fade_sequencer #(
    parameter int PWM_BITS = 8,
    parameter int TICK_DIV = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3*PWM_BITS-1:0] cmd_rgb,
    input  logic [7:0]            cmd_hold,
    output logic                  led_r,
    output logic                  led_g,
    output logic                  led_b,
    output logic                  busy,
    output logic [3*PWM_BITS-1:0] cur_rgb
);
    localparam int NUM_CH = 3;
    localparam int TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;

    state_t                              state, state_nxt;
    logic [PWM_BITS-1:0]                 pwm_cnt;
    logic [TW-1:0]                       tick_cnt;
    logic [7:0]                          hold_cnt;
    logic                                tick, accept, all_at, step;
    logic [NUM_CH-1:0][PWM_BITS-1:0]     tgt_ch, cur_ch;
    logic [NUM_CH-1:0]                   at_ch, led_ch;

    assign tgt_ch  = cmd_rgb;
    assign cur_rgb = cur_ch;
    assign led_r   = led_ch[2];
    assign led_g   = led_ch[1];
    assign led_b   = led_ch[0];

    assign tick   = (tick_cnt == TICK_MAX);
    assign accept = cmd_valid && cmd_ready;
    assign all_at = &at_ch;
    // Completion wins over a coincident tick, so the last step is followed
    // by one FADE cycle that observes cur==target.
    assign step   = (state == FADE) && tick && !all_at;

    genvar ch;
    generate
        for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
            rgb_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
                .clk      (clk),
                .rst      (rst),
                .load     (accept),
                .load_val (tgt_ch[ch]),
                .step     (step),
                .pwm_cnt  (pwm_cnt),
                .pwm_wrap (&pwm_cnt),
                .cur      (cur_ch[ch]),
                .at_tgt   (at_ch[ch]),
                .led      (led_ch[ch])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pwm_cnt  <= '0;
            tick_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            // Restart on accept so the first tick is a full TICK_DIV away.
            if (accept || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TW'(1);
            if (accept)
                hold_cnt <= cmd_hold;
            else if (state == HOLD && tick && hold_cnt != 8'd0)
                hold_cnt <= hold_cnt - 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid)
                    state_nxt = FADE;
            end
            FADE: if (all_at) state_nxt = HOLD;
            HOLD: if (hold_cnt == 8'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
module tb_rgb_fade_sequencer;
    localparam int PB = 4;
    localparam int TD = 4;
    localparam int PER = 1 << PB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_rgb = '0;
    logic [7:0]  cmd_hold = '0;
    logic        led_r, led_g, led_b, busy;
    logic [11:0] cur_rgb;

    rgb_fade_sequencer #(.PWM_BITS(PB), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rgb(cmd_rgb), .cmd_hold(cmd_hold), .led_r(led_r), .led_g(led_g),
        .led_b(led_b), .busy(busy), .cur_rgb(cur_rgb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc;   // clk edges since reset release

    always @(posedge clk or negedge rst)
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;

    // kind: 0 = busy rises, 1 = cur_rgb changes, 2 = busy falls
    typedef struct {int kind; int at; logic [11:0] rgb;} ev_t;
    ev_t q[$];
    int  m_cur[3];
    int  m_idle = -1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic pop_chk(input int kind, input int rgb);
        ev_t ev;
        if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_event kind=%0d actual_rgb=%0h expected=none cyc=%0d", kind, rgb, cyc);
        end else begin
            ev = q.pop_front();
            chk("ev_kind", kind, ev.kind);
            chk("ev_cycle", cyc, ev.at);
            if (kind == 1) chk("ev_rgb", rgb, int'(ev.rgb));
            if (kind == 0) chk("ready_when_busy", int'(cmd_ready), 0);
            if (kind == 2) chk("ready_when_idle", int'(cmd_ready), 1);
        end
    endtask

    // Event monitor
    logic        prev_busy;
    logic [11:0] prev_cur;
    always @(negedge clk) begin
        if (!rst) begin
            prev_busy = 1'b0;
            prev_cur  = '0;
        end else begin
            if (busy && !prev_busy)     pop_chk(0, 0);
            if (cur_rgb != prev_cur)    pop_chk(1, int'(cur_rgb));
            if (!busy && prev_busy)     pop_chk(2, 0);
            prev_busy = busy;
            prev_cur  = cur_rgb;
        end
    end

    // PWM window monitor: the duty visible at the start of each period must
    // produce exactly that many high cycles over the following period.
    int wcnt[3];
    int dcur[3];
    int dnext[3];
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin wcnt[i] = 0; dcur[i] = 0; dnext[i] = 0; end
        end else if (cyc > 0) begin
            wcnt[0] += int'(led_r);
            wcnt[1] += int'(led_g);
            wcnt[2] += int'(led_b);
            if (cyc % PER == PER - 1) begin
                dnext[0] = int'(cur_rgb[11:8]);
                dnext[1] = int'(cur_rgb[7:4]);
                dnext[2] = int'(cur_rgb[3:0]);
            end
            if (cyc % PER == 0) begin
                chk("duty_r", wcnt[0], dcur[0]);
                chk("duty_g", wcnt[1], dcur[1]);
                chk("duty_b", wcnt[2], dcur[2]);
                for (int i = 0; i < 3; i++) begin wcnt[i] = 0; dcur[i] = dnext[i]; end
            end
        end
    end

    // Drive a command (call right after a negedge), predict its whole
    // observable trajectory, and return once it has been accepted.
    task automatic issue(input logic [11:0] rgb, input logic [7:0] hold, output int acc);
        int c, e, l, idle, d, stp, val, guard;
        int t[3];
        logic [11:0] v;
        c = cyc;
        e = (c + 1 > m_idle + 1) ? c + 1 : m_idle + 1;
        cmd_valid = 1'b1;
        cmd_rgb   = rgb;
        cmd_hold  = hold;
        t[0] = int'(rgb[11:8]); t[1] = int'(rgb[7:4]); t[2] = int'(rgb[3:0]);
        l = 0;
        for (int ch = 0; ch < 3; ch++) begin
            d = t[ch] - m_cur[ch];
            if (d < 0) d = -d;
            if (d > l) l = d;
        end
        q.push_back('{0, e, 12'h0});
        for (int i = 1; i <= l; i++) begin
            for (int ch = 0; ch < 3; ch++) begin
                d = t[ch] - m_cur[ch];
                stp = (d < 0) ? -d : d;
                if (stp > i) stp = i;
                val = (d < 0) ? m_cur[ch] - stp : m_cur[ch] + stp;
                v[(2 - ch) * 4 +: 4] = val[3:0];
            end
            q.push_back('{1, e + TD * i, v});
        end
        idle = (hold == 0) ? e + TD * l + 2 : e + TD * (l + int'(hold)) + 1;
        q.push_back('{2, idle, 12'h0});
        m_idle = idle;
        for (int ch = 0; ch < 3; ch++) m_cur[ch] = t[ch];
        acc = e;
        guard = 0;
        while (cyc < e && guard < 5000) begin @(negedge clk); guard++; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_led_r", int'(led_r), 0);
        chk("rst_led_g", int'(led_g), 0);
        chk("rst_led_b", int'(led_b), 0);
        chk("rst_cur_rgb", int'(cur_rgb), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        q.delete();
        for (int ch = 0; ch < 3; ch++) m_cur[ch] = 0;
        m_idle = -1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic settle(input int extra);
        int guard = 0;
        while (cyc < m_idle + extra && guard < 5000) begin @(negedge clk); guard++; end
    endtask

    initial begin
        int acc, guard;
        for (int ch = 0; ch < 3; ch++) m_cur[ch] = 0;
        do_reset();

        // Fade up red and hold
        issue(12'h300, 8'd2, acc);
        cmd_valid = 1'b0;
        repeat (40) @(negedge clk);
        // Target equals current colour
        issue(12'h300, 8'd0, acc);
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        // Mixed-direction fade
        issue(12'h020, 8'd0, acc);
        cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        // Back-pressure: second command held valid while the first runs
        issue(12'hF0F, 8'd1, acc);
        issue(12'h0F1, 8'd0, acc);
        cmd_valid = 1'b0;
        settle(20);

        // Full brightness, then async reset while an LED is lit
        issue(12'hFFF, 8'd1, acc);
        cmd_valid = 1'b0;
        settle(20);
        guard = 0;
        while (!led_r && guard < 40) begin @(negedge clk); guard++; end
        chk("led_r_lit_before_reset", int'(led_r), 1);
        do_reset();
        repeat (3 * PER) @(negedge clk);

        // Reset in the middle of a ramp, then a fresh short fade
        issue(12'h300, 8'd0, acc);
        cmd_valid = 1'b0;
        guard = 0;
        while (cyc < acc + 9 && guard < 100) begin @(negedge clk); guard++; end
        chk("mid_fade_cur_r", int'(cur_rgb[11:8]), 2);
        do_reset();
        issue(12'h001, 8'd0, acc);
        cmd_valid = 1'b0;
        settle(5);

        // Random commands with random gaps and back-to-back requests
        for (int n = 0; n < 25; n++) begin
            issue(12'($urandom_range(0, 4095)), 8'($urandom_range(0, 3)), acc);
            if ($urandom_range(0, 2) != 0) begin
                cmd_valid = 1'b0;
                cmd_rgb   = 12'($urandom);
                cmd_hold  = 8'($urandom);
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        settle(40);
        chk("events_outstanding", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
